rr_stream_mux: RTL and testbench

- Parametrised N-channel to 1 stream multiplexer; successor to the fixed 4:1 combinational MUX421.
- Replaces the external select input with internal round-robin arbitration among requesting channels.
- Uses per-channel valid/ready handshakes and a registered output stage.
- Sits between several producer blocks and one shared consumer, e.g. a shared bus or output port.

---
 rtl/rr_stream_mux.sv | 98 +++++++++
 tb/tb_rr_stream_mux.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N-channel to 1 stream multiplexer with round-robin arbitration and a registered output stage.
// Optional packet locking (in_last/out_last) is enabled by defining RRMUX_LAST_EN.
module rr_stream_mux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NCH   = 4,
  parameter int unsigned SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
`ifdef RRMUX_LAST_EN
  input  logic [NCH-1:0]       in_last,
`endif
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
`ifdef RRMUX_LAST_EN
  output logic                 out_last,
`endif
  input  logic                 out_ready
);

  logic             load;
  logic             xfer;
  logic             grant_vld;
  logic [SELW-1:0]  grant;
  logic [SELW-1:0]  ptr_q;
  logic [WIDTH-1:0] grant_data;
`ifdef RRMUX_LAST_EN
  logic             lock_q;
`endif

  assign load = !out_valid || out_ready;
  assign xfer = load && grant_vld;

  always_comb begin
    int idx;
    idx       = 0;
    grant     = ptr_q;
    grant_vld = 1'b0;
    // Walk from the farthest candidate back to ptr+1 so the nearest requester wins.
    for (int k = int'(NCH); k >= 1; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= int'(NCH)) idx = idx - int'(NCH);
      if (in_valid[idx]) begin
        grant     = SELW'(idx);
        grant_vld = 1'b1;
      end
    end
`ifdef RRMUX_LAST_EN
    // A packet in progress owns the output; ptr_q holds its channel.
    if (lock_q) begin
      grant     = ptr_q;
      grant_vld = in_valid[ptr_q];
    end
`endif
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (int'(grant) == i) begin
        grant_data  = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = load && grant_vld;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr_q     <= SELW'(NCH - 1);
`ifdef RRMUX_LAST_EN
      out_last  <= 1'b0;
      lock_q    <= 1'b0;
`endif
    end else if (load) begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        ptr_q     <= grant;
`ifdef RRMUX_LAST_EN
        out_last  <= in_last[grant];
        lock_q    <= !in_last[grant];
`endif
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: a 4-channel and a 3-channel instance.
// Packet-lock scenarios run only when RRMUX_LAST_EN is defined.
module tb_rr_stream_mux;

  typedef logic [10:0] entry_t;  // {last, sel[1:0], data[7:0]}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [7:0]  din [4];
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, in_last;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_valid, out_ready;

  logic [7:0]  din3 [3];
  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_ready3, in_last3;
  logic [7:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_valid3, out_ready3;

`ifdef RRMUX_LAST_EN
  logic out_last, out_last3;
`endif

  assign in_data  = {din[3], din[2], din[1], din[0]};
  assign in_data3 = {din3[2], din3[1], din3[0]};

  rr_stream_mux #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
`ifdef RRMUX_LAST_EN
    .in_last   (in_last),
`endif
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
`ifdef RRMUX_LAST_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  rr_stream_mux #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .in_valid  (in_valid3),
`ifdef RRMUX_LAST_EN
    .in_last   (in_last3),
`endif
    .in_ready  (in_ready3),
    .out_data  (out_data3),
    .out_sel   (out_sel3),
    .out_valid (out_valid3),
`ifdef RRMUX_LAST_EN
    .out_last  (out_last3),
`endif
    .out_ready (out_ready3)
  );

  int     vectors     = 0;
  int     miscompares = 0;
  entry_t q4[$];
  entry_t q3[$];
  entry_t e4, e3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q4.size() == 0) begin
        chk("beat4 unexpected", 32'd1, 32'd0);
      end else begin
        e4 = q4.pop_front();
        chk("beat4 sel", 32'(out_sel), 32'(e4[9:8]));
        chk("beat4 data", 32'(out_data), 32'(e4[7:0]));
`ifdef RRMUX_LAST_EN
        chk("beat4 last", 32'(out_last), 32'(e4[10]));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      if (q3.size() == 0) begin
        chk("beat3 unexpected", 32'd1, 32'd0);
      end else begin
        e3 = q3.pop_front();
        chk("beat3 sel", 32'(out_sel3), 32'(e3[9:8]));
        chk("beat3 data", 32'(out_data3), 32'(e3[7:0]));
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    in_valid   = '0;
    in_last    = '0;
    out_ready  = 1'b0;
    in_valid3  = '0;
    in_last3   = '0;
    out_ready3 = 1'b0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    for (int i = 0; i < 3; i++) din3[i] = 8'h00;
    repeat (2) tick();
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset out_data", 32'(out_data), 32'd0);
    chk("reset out_sel", 32'(out_sel), 32'd0);
    rst_n = 1'b1;
    tick();

    // Single requester on channel 2.
    din[2]    = 8'hA5;
    in_valid  = 4'b0100;
    out_ready = 1'b1;
    #1;
    chk("single in_ready", 32'(in_ready), 32'h4);
    q4.push_back({1'b0, 2'd2, 8'hA5});
    tick();
    chk("single out_valid", 32'(out_valid), 32'd1);
    chk("single out_data", 32'(out_data), 32'hA5);
    chk("single out_sel", 32'(out_sel), 32'd2);
    in_valid = '0;
    tick();
    chk("idle out_valid", 32'(out_valid), 32'd0);

    // Round robin from reset pointer, all four requesting.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = 8'h10 + 8'(i);
    in_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr in_ready", 32'(in_ready), 32'd1 << (k % 4));
      q4.push_back({1'b0, 2'(k % 4), 8'h10 + 8'(k % 4)});
      tick();
      chk("rr no gap", 32'(out_valid), 32'd1);
    end

    // Backpressure stall with ch3 beat held.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall in_ready", 32'(in_ready), 32'd0);
      chk("stall out_data", 32'(out_data), 32'h13);
      chk("stall out_sel", 32'(out_sel), 32'd3);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("resume in_ready", 32'(in_ready), 32'h1);
    q4.push_back({1'b0, 2'd0, 8'h10});
    tick();
    in_valid = '0;
    repeat (2) tick();

    // Asynchronous reset with a beat held in the output register.
    din[0]    = 8'h77;
    in_valid  = 4'b0001;
    out_ready = 1'b0;
    tick();
    chk("pre-reset out_valid", 32'(out_valid), 32'd1);
    in_valid = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst out_valid", 32'(out_valid), 32'd0);
    chk("async rst out_data", 32'(out_data), 32'd0);
    chk("async rst out_sel", 32'(out_sel), 32'd0);
    #2;
    rst_n     = 1'b1;
    din[0]    = 8'h10;
    in_valid  = 4'hF;
    out_ready = 1'b1;
    #1;
    chk("post-reset grant", 32'(in_ready), 32'h1);
    q4.push_back({1'b0, 2'd0, 8'h10});
    tick();
    in_valid = '0;
    repeat (2) tick();

    // Three-channel instance: pointer must wrap from 2 to 0.
    for (int i = 0; i < 3; i++) din3[i] = 8'h30 + 8'(i);
    in_valid3  = 3'b111;
    out_ready3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("nch3 in_ready", 32'(in_ready3), 32'd1 << (k % 3));
      q3.push_back({1'b0, 2'(k % 3), 8'h30 + 8'(k % 3)});
      tick();
    end
    in_valid3 = '0;
    repeat (2) tick();

`ifdef RRMUX_LAST_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    // Single-beat ch0 packet moves the pointer to 0.
    din[0]   = 8'h40;
    in_last  = 4'b0001;
    in_valid = 4'b0001;
    #1;
    q4.push_back({1'b1, 2'd0, 8'h40});
    tick();
    din[0]   = 8'h41;
    din[3]   = 8'h43;
    in_last  = 4'b1001;
    in_valid = 4'b1011;
    for (int b = 1; b <= 3; b++) begin
      din[1]     = 8'h50 + 8'(b);
      in_last[1] = (b == 3);
      #1;
      chk("pkt lock in_ready", 32'(in_ready), 32'h2);
      q4.push_back({(b == 3), 2'd1, 8'h50 + 8'(b)});
      tick();
    end
    in_valid = 4'b1001;
    #1;
    chk("after pkt grant3", 32'(in_ready), 32'h8);
    q4.push_back({1'b1, 2'd3, 8'h43});
    tick();
    #1;
    chk("after pkt grant0", 32'(in_ready), 32'h1);
    q4.push_back({1'b1, 2'd0, 8'h41});
    tick();
    // ch1 drops valid mid-packet: bubble, others stay locked out.
    in_valid   = 4'b1011;
    in_last[1] = 1'b0;
    din[1]     = 8'h61;
    #1;
    chk("drop first grant", 32'(in_ready), 32'h2);
    q4.push_back({1'b0, 2'd1, 8'h61});
    tick();
    in_valid = 4'b1001;
    #1;
    chk("drop in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("drop bubble", 32'(out_valid), 32'd0);
    chk("drop still locked", 32'(in_ready), 32'h0);
    in_valid   = 4'b1011;
    in_last[1] = 1'b1;
    din[1]     = 8'h62;
    #1;
    chk("drop resume", 32'(in_ready), 32'h2);
    q4.push_back({1'b1, 2'd1, 8'h62});
    tick();
    in_valid = '0;
    repeat (2) tick();
`endif

    repeat (2) tick();
    chk("q4 drained", 32'(q4.size()), 32'd0);
    chk("q3 drained", 32'(q3.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
